// File: rtl/cfu_share_arbiter_pkg.sv
// Shared constants and helpers for the CFU sharing arbiter and its id FIFO.
package cfu_share_arbiter_pkg;

  localparam int unsigned CfuFunctionIdW = 1;
  localparam int unsigned CfuReqInputs   = 2;
  localparam int unsigned CfuReqDataW    = 32;
  localparam int unsigned CfuRespDataW   = 32;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/cfu_id_fifo.sv
// Synchronous FIFO of requester indices; Depth must be a power of two so
// the read/write pointers wrap naturally.
module cfu_id_fifo
  import cfu_share_arbiter_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       din,
  output logic [Width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(Depth):0]  count
);

  localparam int unsigned PtrW = clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cfu_share_arbiter.sv
// Shares one in-order CFU between N_REQ requesters: round-robin request arbitration
// with stall lock, and an id FIFO steering each response back to its issuer.
module cfu_share_arbiter
  import cfu_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ             = 2,
  parameter int unsigned CFU_FUNCTION_ID_W = CfuFunctionIdW,
  parameter int unsigned CFU_REQ_INPUTS    = CfuReqInputs,
  parameter int unsigned CFU_REQ_DATA_W    = CfuReqDataW,
  parameter int unsigned CFU_RESP_DATA_W   = CfuRespDataW,
  parameter int unsigned OUTSTANDING       = 4
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [N_REQ-1:0]                                  up_req_valid,
  output logic [N_REQ-1:0]                                  up_req_ready,
  input  logic [N_REQ*CFU_FUNCTION_ID_W-1:0]                up_req_func,
  input  logic [N_REQ*CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]    up_req_data,
  output logic [N_REQ-1:0]                                  up_resp_valid,
  input  logic [N_REQ-1:0]                                  up_resp_ready,
  output logic [CFU_RESP_DATA_W-1:0]                        up_resp_data,
  output logic                                              up_resp_err,
  output logic                                              cfu_req_valid,
  input  logic                                              cfu_req_ready,
  output logic [CFU_FUNCTION_ID_W-1:0]                      cfu_req_func,
  output logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]          cfu_req_data,
  input  logic                                              cfu_resp_valid,
  output logic                                              cfu_resp_ready,
  input  logic [CFU_RESP_DATA_W-1:0]                        cfu_resp_data,
  input  logic                                              cfu_resp_err,
  output logic [clog2(OUTSTANDING):0]                       inflight,
  output logic                                              proto_err
);

  localparam int unsigned IdW = id_width(N_REQ);
  localparam int unsigned OpW = CFU_REQ_INPUTS * CFU_REQ_DATA_W;
  localparam int unsigned FnW = CFU_FUNCTION_ID_W;

  logic [IdW-1:0] rr_q;
  logic [IdW-1:0] lock_idx_q;
  logic           lock_q;
  logic           proto_err_q;

  logic [IdW-1:0] grant_idx;
  logic           grant_found;
  logic [IdW:0]   cand;
  logic [IdW-1:0] head_idx;
  logic           fifo_full;
  logic           fifo_empty;
  logic           req_hs;
  logic           resp_live;
  logic           resp_hs;

  // A locked grant holds the offer stable until the CFU accepts it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = lock_idx_q;
    cand        = '0;
    if (lock_q) begin
      grant_found = up_req_valid[lock_idx_q];
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        cand = {1'b0, rr_q} + (IdW + 1)'(i);
        if (cand >= (IdW + 1)'(N_REQ)) cand = cand - (IdW + 1)'(N_REQ);
        if (!grant_found && up_req_valid[cand[IdW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[IdW-1:0];
        end
      end
    end
  end

  assign cfu_req_valid = reset && grant_found && !fifo_full;
  assign req_hs        = cfu_req_valid && cfu_req_ready;

  always_comb begin
    up_req_ready = '0;
    cfu_req_func = '0;
    cfu_req_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_idx == IdW'(i)) begin
        cfu_req_func = up_req_func[i*FnW +: FnW];
        cfu_req_data = up_req_data[i*OpW +: OpW];
      end
    end
    up_req_ready[grant_idx] = req_hs;
  end

  // Responses only leave while an issued request is outstanding.
  assign resp_live      = reset && !fifo_empty;
  assign cfu_resp_ready = resp_live && up_resp_ready[head_idx];
  assign resp_hs        = cfu_resp_valid && cfu_resp_ready;
  assign up_resp_data   = cfu_resp_data;
  assign up_resp_err    = cfu_resp_err;

  always_comb begin
    up_resp_valid           = '0;
    up_resp_valid[head_idx] = cfu_resp_valid && resp_live;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (req_hs) begin
        rr_q   <= (grant_idx == IdW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        lock_q <= 1'b0;
      end else if (cfu_req_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end
      if (cfu_resp_valid && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;

  cfu_id_fifo #(
    .Width (IdW),
    .Depth (OUTSTANDING)
  ) u_id_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_hs),
    .pop   (resp_hs),
    .din   (grant_idx),
    .dout  (head_idx),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (inflight)
  );

endmodule
